// File: rtl/out_fm_pkg.sv
// out_fm_pkg: shared state encoding, default tile geometry and a width helper
// for the output feature-map buffer.
package out_fm_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, STORE, DRAIN} state_t;

    localparam int SLICE_SIZE = 64 * 16;
    localparam int FM_SIZE    = 16 * SLICE_SIZE;
    localparam int BANK_DEPTH = FM_SIZE / 4;

    // Ceiling log2, never below 1 so it is always usable as a vector width.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/out_fm_seq.sv
// out_fm_seq: word/lane/group counters and bank address generator shared by
// the load and store sequences.
module out_fm_seq
    import out_fm_pkg::*;
#(
    parameter int AW = 16,
    parameter int Tn = 16,
    parameter int Tr = 64,
    parameter int Tc = 16,
    parameter int Y  = 4,
    parameter int LW = clog2(Y)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          adv,
    output logic [LW-1:0] lane,
    output logic [AW-1:0] addr,
    output logic          last
);
    localparam int SLICE_SIZE = Tr * Tc;
    localparam int FM_SIZE    = Tn * SLICE_SIZE;
    localparam int WW         = clog2(SLICE_SIZE);
    localparam int GW         = clog2(Tn / Y);
    localparam int CW         = clog2(FM_SIZE + 1);

    logic [WW-1:0] word;
    logic [GW-1:0] grp;
    logic [CW-1:0] cnt;
    logic          w_end, l_end;

    assign w_end = word == WW'(SLICE_SIZE - 1);
    assign l_end = lane == LW'(Y - 1);
    assign last  = cnt == CW'(FM_SIZE - 1);
    assign addr  = AW'(grp) * AW'(SLICE_SIZE) + AW'(word);

    always_ff @(posedge clk or posedge rst) begin
        if (rst || clr) begin
            word <= '0;
            lane <= '0;
            grp  <= '0;
            cnt  <= '0;
        end else if (adv) begin
            word <= w_end ? '0 : word + 1'b1;
            lane <= w_end ? (l_end ? '0 : lane + 1'b1) : lane;
            grp  <= (w_end && l_end) ? grp + 1'b1 : grp;
            cnt  <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/output_fm_bank.sv
// output_fm_bank: one simple dual-port bank with a fixed RD_LAT-cycle read pipeline.
module output_fm_bank
    import out_fm_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int DEPTH  = 4096,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);
    localparam int IW = clog2(DEPTH);

    logic [DW-1:0] mem  [DEPTH];
    logic [DW-1:0] pipe [RD_LAT];
    logic          unused_hi;

    // Addresses are zero-extended by the caller; only the low IW bits select a row.
    assign unused_hi = ^{wr_addr, rd_addr};
    assign rd_data   = pipe[RD_LAT-1];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr[IW-1:0]] <= wr_data;
        pipe[0] <= mem[rd_addr[IW-1:0]];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end

endmodule

// File: rtl/output_fm_buf.sv
// output_fm_buf: Y-bank output feature-map buffer with load/store sequencer.
// Define OUT_FM_RELU_EN to clamp negative words to zero on the store path.
module output_fm_buf
    import out_fm_pkg::*;
#(
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int Tn     = 16,
    parameter int Tr     = 64,
    parameter int Tc     = 16,
    parameter int Y      = 4,
    parameter int RD_LAT = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   ld_fifo_data,
    input  logic            ld_fifo_empty,
    output logic            ld_fifo_pop,
    output logic [DW-1:0]   st_fifo_data,
    output logic            st_fifo_push,
    input  logic            st_fifo_almost_full,
    input  logic [Y*AW-1:0] inter_rd_addr,
    output logic [Y*DW-1:0] inter_rd_data,
    input  logic [Y*AW-1:0] inter_wr_addr,
    input  logic [Y*DW-1:0] inter_wr_data,
    input  logic [Y-1:0]    inter_wr_ena,
    input  logic            ld_start,
    output logic            ld_done,
    input  logic            st_start,
    output logic            st_done,
    output logic            compute_en,
    output logic            busy
);
    localparam int SLICE_SIZE = Tr * Tc;
    localparam int FM_SIZE    = Tn * SLICE_SIZE;
    localparam int BANK_DEPTH = FM_SIZE / Y;
    localparam int LW         = clog2(Y);

    if (Tn % Y != 0) begin : g_bad_cfg
        $error("output_fm_buf: Tn must be a multiple of Y");
    end

    state_t        state, state_nx;
    logic          pop, issue, clr, last, drain_end;
    logic [LW-1:0] lane;
    logic [AW-1:0] seq_addr;
    logic [2:0]    dcnt;
    logic [RD_LAT-1:0] iss_d;
    logic [LW-1:0] lane_d  [RD_LAT];
    logic [DW-1:0] bank_rd [Y];
    logic [DW-1:0] rd_word, out_word;

    assign compute_en  = state == IDLE;
    assign busy        = !compute_en;
    assign pop         = state == LOAD && !ld_fifo_empty;
    assign issue       = state == STORE && !st_fifo_almost_full;
    assign clr         = compute_en && (ld_start || st_start);
    assign drain_end   = dcnt == 3'(RD_LAT - 1);
    assign ld_fifo_pop = pop;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = ld_start ? LOAD : st_start ? STORE : IDLE;
            LOAD:    state_nx = (pop && last) ? IDLE : LOAD;
            STORE:   state_nx = (issue && last) ? DRAIN : STORE;
            DRAIN:   state_nx = drain_end ? IDLE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end

    // Issue and lane travel alongside the bank read pipeline so the push lines up with its data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            dcnt    <= '0;
            iss_d   <= '0;
            ld_done <= 1'b0;
            st_done <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) lane_d[i] <= '0;
        end else begin
            state     <= state_nx;
            dcnt      <= (state == DRAIN) ? dcnt + 3'd1 : 3'd0;
            ld_done   <= pop && last;
            st_done   <= state == DRAIN && drain_end;
            iss_d[0]  <= issue;
            lane_d[0] <= lane;
            for (int i = 1; i < RD_LAT; i++) begin
                iss_d[i]  <= iss_d[i-1];
                lane_d[i] <= lane_d[i-1];
            end
        end
    end

    assign st_fifo_push = iss_d[RD_LAT-1];
    assign rd_word      = bank_rd[lane_d[RD_LAT-1]];
`ifdef OUT_FM_RELU_EN
    assign out_word     = rd_word[DW-1] ? '0 : rd_word;
`else
    assign out_word     = rd_word;
`endif
    assign st_fifo_data = st_fifo_push ? out_word : '0;

    out_fm_seq #(.AW(AW), .Tn(Tn), .Tr(Tr), .Tc(Tc), .Y(Y), .LW(LW)) u_seq (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .adv  (pop || issue),
        .lane (lane),
        .addr (seq_addr),
        .last (last)
    );

    for (genvar b = 0; b < Y; b++) begin : g_bank
        logic sel;
        assign sel = lane == LW'(b);
        assign inter_rd_data[b*DW +: DW] = bank_rd[b];
        output_fm_bank #(.AW(AW), .DW(DW), .DEPTH(BANK_DEPTH), .RD_LAT(RD_LAT)) u_bank (
            .clk     (clk),
            .wr_en   (compute_en ? inter_wr_ena[b] : pop && sel),
            .wr_addr (compute_en ? inter_wr_addr[b*AW +: AW] : seq_addr),
            .wr_data (compute_en ? inter_wr_data[b*DW +: DW] : ld_fifo_data),
            .rd_addr (state == STORE ? seq_addr : inter_rd_addr[b*AW +: AW]),
            .rd_data (bank_rd[b])
        );
    end

endmodule

// File: tb/tb_output_fm_buf.sv
// tb_output_fm_buf: scoreboard bench for output_fm_buf (Y=4, Tn=8, Tr=2, Tc=2, RD_LAT=2).
// Store words are queued on st_start and compared as the DUT pushes them.
module tb_output_fm_buf;
    localparam int AW = 8, DW = 32, Tn = 8, Tr = 2, Tc = 2, Y = 4, RD_LAT = 2;
    localparam int N = Tn * Tr * Tc;

    logic            clk = 0, rst = 1;
    logic [DW-1:0]   ld_fifo_data = '0;
    logic            ld_fifo_empty = 1;
    logic            ld_fifo_pop;
    logic [DW-1:0]   st_fifo_data;
    logic            st_fifo_push;
    logic            st_fifo_almost_full = 0;
    logic [Y*AW-1:0] inter_rd_addr = '0;
    logic [Y*DW-1:0] inter_rd_data;
    logic [Y*AW-1:0] inter_wr_addr = '0;
    logic [Y*DW-1:0] inter_wr_data = '0;
    logic [Y-1:0]    inter_wr_ena = '0;
    logic            ld_start = 0, st_start = 0;
    logic            ld_done, st_done, compute_en, busy;

    int          n_cmp = 0, n_bad = 0, cyc = 0, npush = 0, last_push = -10;
    bit          store_active = 0;
    logic [31:0] ld_vals [N];
    logic [31:0] model   [N];
    logic [31:0] stq [$];
    logic [31:0] mon_exp;

    output_fm_buf #(.AW(AW), .DW(DW), .Tn(Tn), .Tr(Tr), .Tc(Tc), .Y(Y), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .ld_fifo_data(ld_fifo_data), .ld_fifo_empty(ld_fifo_empty), .ld_fifo_pop(ld_fifo_pop),
        .st_fifo_data(st_fifo_data), .st_fifo_push(st_fifo_push), .st_fifo_almost_full(st_fifo_almost_full),
        .inter_rd_addr(inter_rd_addr), .inter_rd_data(inter_rd_data),
        .inter_wr_addr(inter_wr_addr), .inter_wr_data(inter_wr_data), .inter_wr_ena(inter_wr_ena),
        .ld_start(ld_start), .ld_done(ld_done), .st_start(st_start), .st_done(st_done),
        .compute_en(compute_en), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] relu(input logic [31:0] v);
`ifdef OUT_FM_RELU_EN
        return v[31] ? 32'h0 : v;
`else
        return v;
`endif
    endfunction

    always @(negedge clk) begin
        if (st_fifo_push) begin
            mon_exp = (stq.size() != 0) ? stq.pop_front() : 32'hDEAD_BEEF;
            check("st_data", st_fifo_data, mon_exp);
            npush++;
            last_push = cyc;
        end
        if (st_done) begin
            check("st_done_active", {31'd0, store_active}, 32'd1);
            check("st_done_cyc", cyc, last_push + 1);
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pop"}, ld_fifo_pop, 0);
        check({tag, "_push"}, st_fifo_push, 0);
        check({tag, "_data"}, st_fifo_data, 0);
        check({tag, "_ld_done"}, ld_done, 0);
        check({tag, "_st_done"}, st_done, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_cen"}, compute_en, 1);
    endtask

    // Compute-port writes are held active throughout the load; they must be ignored.
    task automatic do_load(input bit both);
        int i, k;
        bit popped;
        @(posedge clk); #1;
        ld_start = 1; st_start = both;
        @(posedge clk); #1;
        ld_start = 0; st_start = 0;
        check("ld_busy", busy, 1);
        check("ld_cen", compute_en, 0);
        inter_wr_ena = '1; inter_wr_addr = '0; inter_wr_data = '1;
        i = 0; k = 0;
        while (i < N && k < 300) begin
            ld_fifo_empty = (k % 7 == 3);
            ld_fifo_data  = ld_vals[i];
            st_start      = (k == 5);
            #3;
            if (ld_fifo_empty) check("pop_empty", ld_fifo_pop, 0);
            popped = ld_fifo_pop;
            @(posedge clk); #1;
            if (popped) i++;
            k++;
        end
        ld_fifo_empty = 1; st_start = 0; inter_wr_ena = '0;
        if (i < N) check("ld_timeout", i, N);
        check("ld_done", ld_done, 1);
        check("ld_busy_fall", busy, 0);
        for (int j = 0; j < N; j++) model[j] = ld_vals[j];
        @(posedge clk); #1;
        check("ld_done_pulse", ld_done, 0);
        check("ld_no_store", busy, 0);
    endtask

    task automatic do_store(input bit tog, input int abort_at);
        int s, base, k;
        bit got_first, done;
        for (int i = 0; i < N; i++) stq.push_back(relu(model[i]));
        base = npush; got_first = 0; done = 0; k = 0;
        @(posedge clk); #1;
        st_start = 1; s = cyc; store_active = 1;
        @(posedge clk); #1;
        st_start = 0;
        while (!done && k < 400) begin
            if (tog) st_fifo_almost_full = (k % 6 >= 3);
            #3;
            if (st_fifo_push && !got_first) begin
                if (!tog) check("st_latency", cyc, s + 1 + RD_LAT);
                got_first = 1;
            end
            if (abort_at > 0 && npush - base >= abort_at) begin
                rst = 1; #1;
                check_reset_outputs("abort");
                stq.delete(); store_active = 0; done = 1;
                @(posedge clk); #1;
                rst = 0;
            end else if (st_done) begin
                check("st_busy_fall", busy, 0);
                done = 1;
            end else begin
                @(posedge clk); #1;
            end
            k++;
        end
        st_fifo_almost_full = 0;
        if (!done) check("st_timeout", k, 0);
        @(negedge clk); #1;
        check("st_leftover", stq.size(), 0);
        store_active = 0;
    endtask

    initial begin
        #12;
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 0;

        for (int i = 0; i < N; i++) ld_vals[i] = i;
        do_load(0);
        for (int a = 0; a < N / Y; a++) begin
            inter_rd_addr = {Y{8'(a)}};
            repeat (RD_LAT) @(posedge clk);
            #1;
            for (int b = 0; b < Y; b++)
                check($sformatf("bank%0d_a%0d", b, a), inter_rd_data[b*DW +: DW], ((a / 4) * 4 + b) * 4 + a % 4);
        end

        do_store(0, 0);
        do_store(1, 0);

        @(posedge clk); #1;
        inter_wr_ena = 4'b0001; inter_wr_addr = '0; inter_wr_data[31:0] = 32'hAAAA_0001;
        @(posedge clk); #1;
        inter_wr_ena = '0;
        model[0] = 32'hAAAA_0001;
        do_store(0, 0);

        for (int i = 0; i < N; i++) ld_vals[i] = (i % 5 == 0) ? (32'h8000_0000 | i) : i + 100;
        ld_vals[0] = 32'h8000_0005;
        ld_vals[1] = 32'h0000_0007;
        do_load(1);
        do_store(0, 0);

        do_store(0, 10);
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("post_abort");

        for (int i = 0; i < N; i++) ld_vals[i] = i + 200;
        do_load(0);
        do_store(0, 0);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/output_fm_buf.md
# output_fm_buf

Parametrised output feature-map buffer holding Tn output channels of one Tr×Tc tile, spread round-robin over Y banks (slice k lives in bank k mod Y). It sits between the conv memory-access FIFOs and the PE array. It loads partial sums from the load FIFO, hands all banks to the compute logic, then drains the tile to the store FIFO. It adds to the previous generation: a generic bank count, a configurable bank read latency, an explicit load/store sequencer with busy/abort semantics, and optional ReLU on the store path.

## Interface
- AW, 16: per-bank address width; must be ≥ clog2(Tn/Y·Tr·Tc)
- DW, 32: data width
- Tn, 16: channels per tile; Tn mod Y == 0 required (elaboration error otherwise)
- Tr, 64: tile rows
- Tc, 16: tile cols
- Y, 4: number of banks, 1..16
- RD_LAT, 2: bank read latency in cycles, 1..4
- clk  in  1  clock; single clock domain
- rst  in  1  asynchronous, active-high reset
- ld_fifo_data  in  DW  load FIFO head word
- ld_fifo_empty  in  1  load FIFO empty
- ld_fifo_pop  out  1  pop strobe; the word is consumed in the same cycle
- st_fifo_data  out  DW  store word
- st_fifo_push  out  1  store push strobe
- st_fifo_almost_full  in  1  asserted while free slots ≤ RD_LAT
- inter_rd_addr  in  Y*AW  compute read addresses, bank b at [b*AW +: AW]
- inter_rd_data  out  Y*DW  compute read data; valid RD_LAT cycles after the address
- inter_wr_addr  in  Y*AW  compute write addresses
- inter_wr_data  in  Y*DW  compute write data
- inter_wr_ena  in  Y  compute write enables
- ld_start  in  1  start load (single-cycle pulse)
- ld_done  out  1  one-cycle pulse: load complete
- st_start  in  1  start store (single-cycle pulse)
- st_done  out  1  one-cycle pulse: store complete
- compute_en  out  1  high when the compute port owns the banks
- busy  out  1  high in LOAD, STORE or DRAIN

## Operation
- States: IDLE, LOAD, STORE, DRAIN. Reset state is IDLE.
- IDLE: compute_en=1 and inter_* writes go to the banks. In LOAD, STORE and DRAIN, inter_wr_ena is ignored.
- IDLE→LOAD on ld_start. IDLE→STORE on st_start. If both pulse in the same cycle, LOAD wins and st_start is dropped. A start in any state other than IDLE is ignored.
- LOAD:
  - pop = !ld_fifo_empty.
  - Each pop writes the word to bank lane_sel at address grp·Tr·Tc + word.
  - word counts 0..Tr·Tc−1. On wrap, lane advances 0..Y−1. On lane wrap, grp increments.
  - The last pop (Tn·Tr·Tc-th) moves the FSM to IDLE and fires ld_done in the next cycle.
- STORE:
  - Read issue = !st_fifo_almost_full, using the same address/lane sequencing as LOAD.
  - Lane select and issue are delayed RD_LAT cycles. The delayed issue becomes st_fifo_push and muxes the delayed lane's bank data.
  - After the last issue the FSM enters DRAIN.
- DRAIN: waits RD_LAT cycles for in-flight reads, then goes to IDLE and pulses st_done on the last push cycle + 1.
- Counters (word, lane, grp) clear on every start, so a new tile always begins at bank 0, address 0.
- Widths: the total counter is clog2(Tn·Tr·Tc+1) bits. Bank addresses are zero-extended to AW.

## Timing
- Reset values: ld_fifo_pop=0, st_fifo_push=0, st_fifo_data=0, ld_done=0, st_done=0, busy=0, compute_en=1. The delay pipeline clears on reset.
- Load throughput is 1 word/cycle while the FIFO is non-empty. Bank write lands 1 cycle after the pop.
- Store latency: issue→push is exactly RD_LAT cycles. Throughput is 1 word/cycle while not almost_full.
- busy rises the cycle after a start. busy falls in the same cycle ld_done/st_done is high.
- Reset mid-operation aborts immediately. Bank contents are undefined afterwards, and no done pulse is produced.

## Configuration
- OUT_FM_RELU_EN defined: st_fifo_data = 0 when the sign bit [DW−1] of the bank word is set, otherwise the word. No added latency.
- Not defined: store data is passed through unchanged.

## Structure
- Package out_fm_pkg holds:
  - the state enum
  - localparams SLICE_SIZE=Tr·Tc, FM_SIZE=Tn·Tr·Tc, BANK_DEPTH=FM_SIZE/Y
  - a clog2 helper
- Y instances of the existing output_fm_bank, generated in a loop.
- One new sub-module, out_fm_seq, holds the word/lane/grp counters and the address generator. It is shared by LOAD and STORE, which never overlap.

## Test plan
- Load with Y=4, Tn=8, Tr=2, Tc=2, values 0..31 → bank b address a holds (a/4·4+b)·4 + a%4. ld_done fires 1 cycle after pop #32.
- Store after that load → st_fifo_data emits 0..31 in order, first push RD_LAT cycles after st_start+1, st_done 1 cycle after the last push.
- Toggle almost_full every 3 cycles during store → no word lost or duplicated, and order is preserved.
- ld_start and st_start in the same cycle → LOAD only. A st_start while busy is ignored.
- rst asserted at word 10 of a store → all outputs return to reset values, no st_done; a subsequent store restarts at word 0.
- With OUT_FM_RELU_EN, load 0x80000005 and 0x7 → store emits 0x0 and 0x7.
